sdram_test_monitor: RTL and testbench
=====================================

Name: sdram_test_monitor

Overview:
- Sits directly downstream of the SDRAM self-test FSM, which exposes `test_in_progress`, `test_result` and an active-high `rst` start input sampled at clk/4.
- Consumes those status levels, issues start pulses, and detects test completion and hangs.
- Keeps saturating pass/fail tallies and drives one status LED for the board test core.

Parameters:
- BLINK_DIV, 24: bit index of the free-running blink counter used for the slow blink; the fast blink uses bit BLINK_DIV-3. Legal range 3..31.
- START_PULSE_LEN, 8: length of the `test_rst` pulse in clk cycles. Must be ≥4 so the clk/4 tester samples it.
- TIMEOUT_CYCLES, 32'd0: maximum clk cycles allowed in WAIT_ACK+RUNNING. 0 disables the timeout.
- RERUN_DELAY, 32'd1000000: clk cycles spent in DONE before an automatic rerun. Used only with SDRAM_MON_AUTORERUN_EN.

Ports:
- clk  in  1  system clock, same clock as the tester
- rst_n  in  1  asynchronous, active-low reset
- pll_locked  in  1  all tester inputs are ignored while this is 0
- start_btn  in  1  level input, already synchronised and debounced; a rising edge requests a test
- test_in_progress  in  1  from the tester
- test_result  in  1  from the tester; valid when test_in_progress falls
- test_rst  out  1  start pulse to the tester's `rst` input
- led_status  out  1  status LED, active high
- last_result  out  1  1 = last test passed
- timeout_flag  out  1  1 = last test ended by timeout
- pass_count  out  8  number of passed tests, saturating
- fail_count  out  8  number of failed tests (including timeouts), saturating
- mon_state  out  3  current FSM state encoding, for debug

Behaviour:
- Reset (rst_n=0, async): state=IDLE; test_rst=0, led_status=0, last_result=0, timeout_flag=0, pass_count=0, fail_count=0; blink counter and timeout counter cleared.
- States and encodings: IDLE=0, START=1, WAIT_ACK=2, RUNNING=3, DONE=4.
- IDLE:
  - start_btn rising edge → START.
  - test_in_progress=1 → RUNNING. This covers the tester's autostart after configuration.
  - If both are true in the same cycle, RUNNING wins and the button edge is dropped.
- START:
  - test_rst=1 for exactly START_PULSE_LEN cycles, then → WAIT_ACK with test_rst=0.
  - If test_in_progress rises during the pulse, the pulse still completes, then → RUNNING.
- WAIT_ACK: test_in_progress=1 → RUNNING. Counts toward the timeout.
- RUNNING, on test_in_progress 1→0 (registered edge, 1-cycle latency), → DONE and:
  - last_result=test_result, timeout_flag=0.
  - test_result=1: pass_count increments, saturating at 255.
  - test_result=0: fail_count increments, saturating at 255.
- Timeout:
  - The counter is cleared on entry to START (button or autorerun) or on IDLE→RUNNING, and increments every cycle in WAIT_ACK/RUNNING.
  - When it reaches TIMEOUT_CYCLES (if nonzero): → DONE, last_result=0, timeout_flag=1, fail_count increments (saturating).
  - A tester completion in the same cycle takes priority over the timeout.
- DONE: start_btn rising edge → START and clear timeout_flag. last_result and the counters hold.
- start_btn edges are ignored in START, WAIT_ACK and RUNNING.
- pll_locked=0 in any state: next cycle → IDLE, test_rst=0. Counters, last_result and timeout_flag are retained.
- LED:
  - IDLE: 0.
  - START/WAIT_ACK/RUNNING: blink[BLINK_DIV].
  - DONE with last_result=1: steady 1.
  - DONE with last_result=0: blink[BLINK_DIV-3].
- Blink counter: 32-bit, free-running, wraps modulo 2^32.

Optional Feature:
- SDRAM_MON_AUTORERUN_EN defined:
  - In DONE with last_result=1, a delay counter runs; after RERUN_DELAY cycles → START.
  - A failure or timeout stays in DONE, latched for inspection.
  - A button press in DONE restarts the test immediately and clears the delay counter.
- Not defined: DONE persists until a button press; no delay counter is synthesised.

Test Plan:
- Bench parameters: START_PULSE_LEN=8, TIMEOUT_CYCLES=200, RERUN_DELAY=50, BLINK_DIV=4.
- Reset, then pll_locked=1, then a start_btn edge:
  - test_rst is high for exactly 8 cycles, then mon_state=2.
  - Raise test_in_progress for 40 cycles, then drop it with test_result=1 → mon_state=4, pass_count=1, last_result=1, led_status steady 1.
- Same sequence with test_result=0 → fail_count=1, last_result=0, led_status toggles every 2 cycles (bit 1).
- start_btn edge, but test_in_progress never rises → after 200 cycles: timeout_flag=1, fail_count increments, mon_state=4.
- Autostart: test_in_progress rises in IDLE with no button → RUNNING, no test_rst pulse.
  - Drop pll_locked mid-run → IDLE, counters unchanged.
- Saturation: run 256 passing tests → pass_count=255.
  - With SDRAM_MON_AUTORERUN_EN, each pass produces a test_rst pulse 50 cycles after entering DONE.
  - A failure produces no further pulses.

Source files
------------

// File: rtl/sdram_test_monitor_if.sv
// Tester handshake bundle for sdram_test_monitor.
// master: monitor side (drives test_rst, observes status levels).
// slave:  SDRAM self-test side.
interface sdram_test_monitor_if;
    logic test_in_progress;
    logic test_result;
    logic test_rst;

    modport master (
        input  test_in_progress,
        input  test_result,
        output test_rst
    );

    modport slave (
        output test_in_progress,
        output test_result,
        input  test_rst
    );
endinterface

// File: rtl/sdram_test_monitor.sv
// sdram_test_monitor: supervises the SDRAM self-test FSM. Issues start pulses,
// detects completion and hangs, keeps saturating pass/fail tallies and drives
// a status LED.
// Optional feature: define SDRAM_MON_AUTORERUN_EN to rerun automatically
// RERUN_DELAY cycles after a passing test.
module sdram_test_monitor #(
    parameter int unsigned BLINK_DIV       = 24,
    parameter int unsigned START_PULSE_LEN = 8,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd0,
    parameter logic [31:0] RERUN_DELAY     = 32'd1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pll_locked,
    input  logic                 start_btn,
    sdram_test_monitor_if.master tst,
    output logic                 led_status,
    output logic                 last_result,
    output logic                 timeout_flag,
    output logic [7:0]           pass_count,
    output logic [7:0]           fail_count,
    output logic [2:0]           mon_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_RUNNING  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic        r_btn_d;
    logic        r_tip_d;
    logic        r_tip_seen;
    logic [31:0] r_pulse_cnt;
    logic [31:0] r_to_cnt;
    // Only bits up to BLINK_DIV are ever observed, so a narrower counter
    // toggles those bits exactly as a 32-bit wrapping counter would.
    logic [BLINK_DIV:0] r_blink;
    logic        r_last_result;
    logic        r_timeout_flag;
    logic [7:0]  r_pass_cnt;
    logic [7:0]  r_fail_cnt;

    logic w_tip;
    logic w_btn_rise;
    logic w_pulse_end;
    logic w_active;
    logic w_complete;
    logic w_timeout;
    logic w_rerun_fire;
    logic w_clr_to;

    // All tester-facing inputs are masked while the PLL is unlocked.
    assign w_tip       = tst.test_in_progress & pll_locked;
    assign w_btn_rise  = start_btn & ~r_btn_d & pll_locked;
    assign w_pulse_end = (r_state == S_START) && (r_pulse_cnt == 32'(START_PULSE_LEN - 1));
    assign w_active    = (r_state == S_WAIT_ACK) || (r_state == S_RUNNING);
    assign w_complete  = (r_state == S_RUNNING) && pll_locked && r_tip_d && !tst.test_in_progress;
    // Completion wins over a timeout landing in the same cycle.
    assign w_timeout   = (TIMEOUT_CYCLES != '0) && w_active && pll_locked && !w_complete &&
                         (r_to_cnt == TIMEOUT_CYCLES - 32'd1);
    assign w_clr_to    = ((w_next == S_START) && (r_state != S_START)) ||
                         ((r_state == S_IDLE) && (w_next == S_RUNNING));

`ifdef SDRAM_MON_AUTORERUN_EN
    logic [31:0] r_delay_cnt;

    // Rerun delay advances only while parked in DONE after a pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_delay_cnt <= '0;
        end else if ((r_state == S_DONE) && r_last_result && (w_next == S_DONE)) begin
            r_delay_cnt <= r_delay_cnt + 32'd1;
        end else begin
            r_delay_cnt <= '0;
        end
    end

    assign w_rerun_fire = (r_state == S_DONE) && r_last_result &&
                          ((r_delay_cnt + 32'd1) >= RERUN_DELAY);
`else
    assign w_rerun_fire = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; loss of PLL lock overrides everything.
    always_comb begin
        w_next = r_state;
        if (!pll_locked) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_tip) begin
                        w_next = S_RUNNING;
                    end else if (w_btn_rise) begin
                        w_next = S_START;
                    end
                end
                S_START: begin
                    if (w_pulse_end) begin
                        w_next = (w_tip || r_tip_seen) ? S_RUNNING : S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (w_timeout) begin
                        w_next = S_DONE;
                    end else if (w_tip) begin
                        w_next = S_RUNNING;
                    end
                end
                S_RUNNING: begin
                    if (w_complete || w_timeout) begin
                        w_next = S_DONE;
                    end
                end
                S_DONE: begin
                    if (w_btn_rise || w_rerun_fire) begin
                        w_next = S_START;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        tst.test_rst = (r_state == S_START);
        mon_state    = r_state;
        led_status   = 1'b0;
        unique case (r_state)
            S_IDLE:                           led_status = 1'b0;
            S_START, S_WAIT_ACK, S_RUNNING:   led_status = r_blink[BLINK_DIV];
            S_DONE:                           led_status = r_last_result ? 1'b1 : r_blink[BLINK_DIV-3];
            default:                          led_status = 1'b0;
        endcase
    end

    // Edge-detect history, pulse length counter and ack-during-pulse latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_d     <= 1'b0;
            r_tip_d     <= 1'b0;
            r_tip_seen  <= 1'b0;
            r_pulse_cnt <= '0;
        end else begin
            r_btn_d <= start_btn;
            r_tip_d <= w_tip;
            if ((r_state == S_START) && (w_next == S_START)) begin
                r_pulse_cnt <= r_pulse_cnt + 32'd1;
                r_tip_seen  <= r_tip_seen | w_tip;
            end else begin
                r_pulse_cnt <= '0;
                r_tip_seen  <= 1'b0;
            end
        end
    end

    // Hang-detection counter over WAIT_ACK and RUNNING.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_clr_to) begin
            r_to_cnt <= '0;
        end else if (w_active && pll_locked) begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end
    end

    // Free-running blink counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink <= '0;
        end else begin
            r_blink <= r_blink + 1'b1;
        end
    end

    // Result latch and saturating tallies; untouched by PLL loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_result  <= 1'b0;
            r_timeout_flag <= 1'b0;
            r_pass_cnt     <= '0;
            r_fail_cnt     <= '0;
        end else if (w_complete) begin
            r_last_result  <= tst.test_result;
            r_timeout_flag <= 1'b0;
            if (tst.test_result) begin
                if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + 8'd1;
            end else begin
                if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 8'd1;
            end
        end else if (w_timeout) begin
            r_last_result  <= 1'b0;
            r_timeout_flag <= 1'b1;
            if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 8'd1;
        end else if ((r_state == S_DONE) && (w_next == S_START)) begin
            r_timeout_flag <= 1'b0;
        end
    end

    assign last_result  = r_last_result;
    assign timeout_flag = r_timeout_flag;
    assign pass_count   = r_pass_cnt;
    assign fail_count   = r_fail_cnt;

endmodule

// File: tb/tb_sdram_test_monitor.sv
// Self-checking bench for sdram_test_monitor.
// Honours SDRAM_MON_AUTORERUN_EN when the design is built with it.
module tb_sdram_test_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       start_btn;
    logic       led_status;
    logic       last_result;
    logic       timeout_flag;
    logic [7:0] pass_count;
    logic [7:0] fail_count;
    logic [2:0] mon_state;

    sdram_test_monitor_if tst();

    sdram_test_monitor #(
        .BLINK_DIV       (4),
        .START_PULSE_LEN (8),
        .TIMEOUT_CYCLES  (32'd200),
        .RERUN_DELAY     (32'd50)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .start_btn    (start_btn),
        .tst          (tst),
        .led_status   (led_status),
        .last_result  (last_result),
        .timeout_flag (timeout_flag),
        .pass_count   (pass_count),
        .fail_count   (fail_count),
        .mon_state    (mon_state)
    );

    always #5 clk = ~clk;

    // Reference blink counter: counts rising edges since reset release.
    logic [31:0] cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= '0;
        else        cyc <= cyc + 32'd1;
    end

    typedef struct {
        logic       last;
        logic       flag;
        logic [7:0] pass;
        logic [7:0] fail;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic       m_last = 1'b0;
    logic       m_flag = 1'b0;
    logic [7:0] m_pass = 8'd0;
    logic [7:0] m_fail = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int budget, input string tag);
        int n = 0;
        while (mon_state !== tgt && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(mon_state), 32'(tgt));
    endtask

    // Predict the outcome of a test ending now and queue it.
    task automatic push_exp(input logic res, input logic to);
        exp_t e;
        if (to) begin
            m_last = 1'b0;
            m_flag = 1'b1;
            if (m_fail != 8'd255) m_fail = m_fail + 8'd1;
        end else begin
            m_last = res;
            m_flag = 1'b0;
            if (res) begin
                if (m_pass != 8'd255) m_pass = m_pass + 8'd1;
            end else begin
                if (m_fail != 8'd255) m_fail = m_fail + 8'd1;
            end
        end
        e.last = m_last;
        e.flag = m_flag;
        e.pass = m_pass;
        e.fail = m_fail;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        chk({tag, "_sb_pending"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_last"}, 32'(last_result), 32'(e.last));
            chk({tag, "_tflag"}, 32'(timeout_flag), 32'(e.flag));
            chk({tag, "_pass"}, 32'(pass_count), 32'(e.pass));
            chk({tag, "_fail"}, 32'(fail_count), 32'(e.fail));
        end
    endtask

    // Waits for test_rst, measures its width, then checks WAIT_ACK follows.
    task automatic measure_pulse(input string tag);
        int n = 0;
        int len = 0;
        while (tst.test_rst !== 1'b1 && n < 80) begin
            step();
            start_btn = 1'b0;
            n++;
        end
        while (tst.test_rst === 1'b1 && len < 40) begin
            len++;
            step();
            start_btn = 1'b0;
        end
        chk({tag, "_pulse_len"}, 32'(len), 32'd8);
        chk({tag, "_post_pulse_state"}, 32'(mon_state), 32'd2);
    endtask

    task automatic run_test(input logic res, input logic press, input int run_len, input string tag);
        if (press) begin
            start_btn = 1'b0;
            step();
            start_btn = 1'b1;
        end
        measure_pulse(tag);
        tst.test_in_progress = 1'b1;
        repeat (run_len) step();
        chk({tag, "_running"}, 32'(mon_state), 32'd3);
        tst.test_in_progress = 1'b0;
        tst.test_result      = res;
        push_exp(res, 1'b0);
        wait_state(3'd4, 10, {tag, "_done"});
        pop_chk(tag);
    endtask

    // Counts DONE samples until the automatic restart shows up.
    task automatic check_rerun_delay(input string tag);
        int d = 0;
        while (mon_state === 3'd4 && d < 200) begin
            d++;
            step();
        end
        chk({tag, "_rerun_delay"}, 32'(d), 32'd50);
    endtask

    initial begin
        int seen;
        rst_n                = 1'b0;
        pll_locked           = 1'b0;
        start_btn            = 1'b0;
        tst.test_in_progress = 1'b0;
        tst.test_result      = 1'b0;
        repeat (3) step();

        chk("rst_state", 32'(mon_state), 32'd0);
        chk("rst_test_rst", 32'(tst.test_rst), 32'd0);
        chk("rst_led", 32'(led_status), 32'd0);
        chk("rst_last", 32'(last_result), 32'd0);
        chk("rst_tflag", 32'(timeout_flag), 32'd0);
        chk("rst_pass", 32'(pass_count), 32'd0);
        chk("rst_fail", 32'(fail_count), 32'd0);

        rst_n = 1'b1;
        step();
        pll_locked = 1'b1;
        repeat (2) step();
        chk("idle_hold", 32'(mon_state), 32'd0);

        // Button-started passing test, LED blinks slow while running.
        start_btn = 1'b1;
        measure_pulse("t1");
        tst.test_in_progress = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            chk("t1_led_run", 32'(led_status), 32'(cyc[4]));
        end
        chk("t1_running", 32'(mon_state), 32'd3);
        tst.test_in_progress = 1'b0;
        tst.test_result      = 1'b1;
        push_exp(1'b1, 1'b0);
        wait_state(3'd4, 10, "t1_done");
        pop_chk("t1");
        for (int i = 0; i < 4; i++) begin
            chk("t1_led_pass", 32'(led_status), 32'd1);
            step();
        end

        // Failing test: fast blink and no automatic rerun.
        run_test(1'b0, 1'b1, 40, "t2");
        for (int i = 0; i < 8; i++) begin
            chk("t2_led_fail", 32'(led_status), 32'(cyc[1]));
            step();
        end
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (tst.test_rst === 1'b1 || mon_state !== 3'd4) seen = 1;
            step();
        end
        chk("t2_latched", 32'(seen), 32'd0);

        // Tester never acknowledges: timeout after 200 cycles.
        start_btn = 1'b1;
        measure_pulse("t3");
        push_exp(1'b0, 1'b1);
        seen = 0;
        while (mon_state === 3'd2 && seen < 300) begin
            seen++;
            step();
        end
        chk("t3_wait_cycles", 32'(seen), 32'd200);
        wait_state(3'd4, 2, "t3_done");
        pop_chk("t3");

        // PLL loss returns to IDLE with tallies retained.
        pll_locked = 1'b0;
        step();
        chk("pll_idle", 32'(mon_state), 32'd0);
        chk("pll_pass", 32'(pass_count), 32'(m_pass));
        chk("pll_fail", 32'(fail_count), 32'(m_fail));
        chk("pll_tflag", 32'(timeout_flag), 32'(m_flag));

        // Autostart from IDLE without any test_rst pulse.
        pll_locked           = 1'b1;
        tst.test_in_progress = 1'b1;
        step();
        chk("auto_running", 32'(mon_state), 32'd3);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (tst.test_rst === 1'b1) seen = 1;
            step();
        end
        chk("auto_no_pulse", 32'(seen), 32'd0);
        pll_locked = 1'b0;
        step();
        chk("midrun_idle", 32'(mon_state), 32'd0);
        chk("midrun_rst", 32'(tst.test_rst), 32'd0);
        chk("midrun_pass", 32'(pass_count), 32'(m_pass));
        chk("midrun_fail", 32'(fail_count), 32'(m_fail));
        chk("midrun_last", 32'(last_result), 32'(m_last));
        tst.test_in_progress = 1'b0;
        step();
        pll_locked = 1'b1;
        repeat (2) step();
        chk("relock_idle", 32'(mon_state), 32'd0);

        // 256 passes: the tally saturates at 255.
        for (int i = 0; i < 256; i++) begin
`ifdef SDRAM_MON_AUTORERUN_EN
            if (i == 0) begin
                run_test(1'b1, 1'b1, 3, "sat");
            end else begin
                check_rerun_delay("sat");
                run_test(1'b1, 1'b0, 3, "sat");
            end
`else
            run_test(1'b1, 1'b1, 3, "sat");
`endif
        end
        chk("sat_pass_255", 32'(pass_count), 32'd255);

        // Final failure stays latched in DONE.
`ifdef SDRAM_MON_AUTORERUN_EN
        check_rerun_delay("last");
        run_test(1'b0, 1'b0, 3, "last");
`else
        run_test(1'b0, 1'b1, 3, "last");
`endif
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (tst.test_rst === 1'b1) seen = 1;
            step();
        end
        chk("last_no_pulse", 32'(seen), 32'd0);
        chk("last_state", 32'(mon_state), 32'd4);
        chk("last_pass_held", 32'(pass_count), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
